// File: rtl/seq_checker_arbitrario_if.sv
// Stream and status bundle between the arbitrary counter, the sequence
// checker and the status/display logic. Clock and reset travel separately.
interface seq_checker_arbitrario_if #(
    parameter int CNT_W = 8
) ();
    logic             En;
    logic [3:0]       SecEntrada;
    logic             Locked;
    logic             ErrPulse;
    logic             Illegal;
    logic [CNT_W-1:0] ErrCount;
    logic [3:0]       Index;
    logic [3:0]       Expected;
    logic [3:0]       ErrData;
    logic [3:0]       ErrExp;

    modport master (
        output En, SecEntrada,
        input  Locked, ErrPulse, Illegal, ErrCount, Index, Expected, ErrData, ErrExp
    );

    modport slave (
        input  En, SecEntrada,
        output Locked, ErrPulse, Illegal, ErrCount, Index, Expected, ErrData, ErrExp
    );
endinterface

// File: rtl/seq_checker_arbitrario.sv
// Sequence checker for the arbitrary 4-bit counter stream
// 3,7,6,6,15,14,7,10,12,14 (positions 0..9). Acquires phase from the anchor
// values, verifies, locks, then flywheels through errors until too many
// consecutive misses drop lock.
// Optional build macro SEQ_ERR_CAPTURE_EN: keep the sample and expected value
// of the first locked mismatch after reset on ErrData/ErrExp (else both are 0).
module seq_checker_arbitrario #(
    parameter int LOCK_COUNT = 3,
    parameter int MAX_MISS   = 2,
    parameter int CNT_W      = 8
) (
    input logic                    C,
    input logic                    R,
    seq_checker_arbitrario_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_N = 4'(MAX_MISS);

    state_t           state_p1;
    logic [3:0]       index_p1;
    logic [3:0]       run_p1;
    logic [3:0]       miss_p1;
    logic             locked_p1;
    logic             err_pulse_p1;
    logic             illegal_p1;
    logic [CNT_W-1:0] err_count_p1;

    logic [3:0]       expected;
    logic [3:0]       next_idx;
    logic [4:0]       anchor;
    logic             match;
    logic             locked_miss;

    function automatic logic [3:0] seq_val(input logic [3:0] pos);
        logic [3:0] v;
        case (pos)
            4'd0:    v = 4'd3;
            4'd1:    v = 4'd7;
            4'd2:    v = 4'd6;
            4'd3:    v = 4'd6;
            4'd4:    v = 4'd15;
            4'd5:    v = 4'd14;
            4'd6:    v = 4'd7;
            4'd7:    v = 4'd10;
            4'd8:    v = 4'd12;
            4'd9:    v = 4'd14;
            default: v = 4'd3;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] pos_inc(input logic [3:0] pos);
        return (pos >= 4'd9) ? 4'd0 : pos + 4'd1;
    endfunction

    // {valid, position} for the values that occur once per cycle
    function automatic logic [4:0] anchor_lookup(input logic [3:0] v);
        logic [4:0] a;
        case (v)
            4'd3:    a = {1'b1, 4'd0};
            4'd15:   a = {1'b1, 4'd4};
            4'd10:   a = {1'b1, 4'd7};
            4'd12:   a = {1'b1, 4'd8};
            default: a = 5'd0;
        endcase
        return a;
    endfunction

    function automatic logic is_legal(input logic [3:0] v);
        logic ok;
        case (v)
            4'd3, 4'd6, 4'd7, 4'd10, 4'd12, 4'd14, 4'd15: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign next_idx    = pos_inc(index_p1);
    assign expected    = seq_val(next_idx);
    assign anchor      = anchor_lookup(bus.SecEntrada);
    assign match       = (bus.SecEntrada == expected);
    assign locked_miss = bus.En && (state_p1 == LOCKED) && !match;

    // Phase acquisition / tracking FSM with registered status outputs
    always_ff @(posedge C) begin
        if (R) begin
            state_p1     <= SEARCH;
            index_p1     <= 4'd0;
            run_p1       <= 4'd0;
            miss_p1      <= 4'd0;
            locked_p1    <= 1'b0;
            err_pulse_p1 <= 1'b0;
            illegal_p1   <= 1'b0;
            err_count_p1 <= '0;
        end else begin
            err_pulse_p1 <= 1'b0;
            illegal_p1   <= 1'b0;
            if (bus.En) begin
                illegal_p1 <= !is_legal(bus.SecEntrada);
                case (state_p1)
                    SEARCH: begin
                        if (anchor[4]) begin
                            index_p1 <= anchor[3:0];
                            run_p1   <= 4'd1;
                            state_p1 <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (match) begin
                            index_p1 <= next_idx;
                            run_p1   <= run_p1 + 4'd1;
                            if (run_p1 + 4'd1 >= LOCK_N) begin
                                state_p1  <= LOCKED;
                                locked_p1 <= 1'b1;
                                miss_p1   <= 4'd0;
                            end
                        end else if (anchor[4]) begin
                            index_p1 <= anchor[3:0];
                            run_p1   <= 4'd1;
                        end else begin
                            state_p1 <= SEARCH;
                            run_p1   <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: position advances whether or not the sample agrees
                        index_p1 <= next_idx;
                        if (match) begin
                            miss_p1 <= 4'd0;
                        end else begin
                            err_pulse_p1 <= 1'b1;
                            err_count_p1 <= sat_inc(err_count_p1);
                            if (miss_p1 + 4'd1 >= MISS_N) begin
                                state_p1  <= SEARCH;
                                locked_p1 <= 1'b0;
                                run_p1    <= 4'd0;
                                miss_p1   <= 4'd0;
                            end else begin
                                miss_p1 <= miss_p1 + 4'd1;
                            end
                        end
                    end
                    default: state_p1 <= SEARCH;
                endcase
            end
        end
    end

`ifdef SEQ_ERR_CAPTURE_EN
    logic       captured_p1;
    logic [3:0] err_data_p1;
    logic [3:0] err_exp_p1;

    // Freeze the first locked mismatch after reset for post-mortem inspection
    always_ff @(posedge C) begin
        if (R) begin
            captured_p1 <= 1'b0;
            err_data_p1 <= 4'd0;
            err_exp_p1  <= 4'd0;
        end else if (locked_miss && !captured_p1) begin
            captured_p1 <= 1'b1;
            err_data_p1 <= bus.SecEntrada;
            err_exp_p1  <= expected;
        end
    end

    assign bus.ErrData = err_data_p1;
    assign bus.ErrExp  = err_exp_p1;
`else
    logic unused_miss;
    assign unused_miss = locked_miss;
    assign bus.ErrData = 4'd0;
    assign bus.ErrExp  = 4'd0;
`endif

    assign bus.Locked   = locked_p1;
    assign bus.ErrPulse = err_pulse_p1;
    assign bus.Illegal  = illegal_p1;
    assign bus.ErrCount = err_count_p1;
    assign bus.Index    = index_p1;
    assign bus.Expected = expected;
endmodule

// File: tb/tb_seq_checker_arbitrario.sv
// Directed bench for seq_checker_arbitrario: a default-width instance and a
// CNT_W=2 instance share the same stimulus; expectations are hand-derived.
module tb_seq_checker_arbitrario;
    logic C = 1'b0;
    logic R = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    seq_checker_arbitrario_if #(.CNT_W(8)) bus_a ();
    seq_checker_arbitrario_if #(.CNT_W(2)) bus_b ();

    seq_checker_arbitrario #(.LOCK_COUNT(3), .MAX_MISS(2), .CNT_W(8)) dut_a (
        .C   (C),
        .R   (R),
        .bus (bus_a.slave)
    );

    seq_checker_arbitrario #(.LOCK_COUNT(3), .MAX_MISS(2), .CNT_W(2)) dut_b (
        .C   (C),
        .R   (R),
        .bus (bus_b.slave)
    );

    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // apply one sample to both instances and settle just past the edge
    task automatic step(input logic en, input logic [3:0] v);
        bus_a.En = en;
        bus_a.SecEntrada = v;
        bus_b.En = en;
        bus_b.SecEntrada = v;
        @(posedge C);
        #1;
    endtask

    task automatic do_reset();
        R = 1'b1;
        step(1'b0, 4'd0);
        R = 1'b0;
    endtask

    logic [3:0] cap_data;
    logic [3:0] cap_exp;

    initial begin
        bus_a.En = 1'b0;
        bus_a.SecEntrada = 4'd0;
        bus_b.En = 1'b0;
        bus_b.SecEntrada = 4'd0;

        // reset state
        do_reset();
        chk("rst_locked",   bus_a.Locked,   0);
        chk("rst_index",    bus_a.Index,    0);
        chk("rst_expected", bus_a.Expected, 7);
        chk("rst_errcount", bus_a.ErrCount, 0);
        chk("rst_errpulse", bus_a.ErrPulse, 0);
        chk("rst_illegal",  bus_a.Illegal,  0);
        chk("rst_errdata",  bus_a.ErrData,  0);
        chk("rst_errexp",   bus_a.ErrExp,   0);

        // clean acquisition from the start of the cycle
        step(1'b1, 4'd3);
        chk("acq_idx0",    bus_a.Index,  0);
        chk("acq_lock0",   bus_a.Locked, 0);
        step(1'b1, 4'd7);
        chk("acq_idx1",    bus_a.Index,  1);
        chk("acq_lock1",   bus_a.Locked, 0);
        step(1'b1, 4'd6);
        chk("acq_locked",  bus_a.Locked,   1);
        chk("acq_idx2",    bus_a.Index,    2);
        chk("acq_exp",     bus_a.Expected, 6);
        chk("acq_errcnt",  bus_a.ErrCount, 0);

        // mid-stream start: 6,6 ignored, anchor on 15
        do_reset();
        step(1'b1, 4'd6);
        step(1'b1, 4'd6);
        chk("mid_search_idx", bus_a.Index, 0);
        step(1'b1, 4'd15);
        chk("mid_anchor_idx", bus_a.Index,  4);
        chk("mid_anchor_lck", bus_a.Locked, 0);
        step(1'b1, 4'd14);
        step(1'b1, 4'd7);
        chk("mid_locked",   bus_a.Locked,   1);
        chk("mid_idx",      bus_a.Index,    6);
        chk("mid_expected", bus_a.Expected, 10);

        // illegal single error while locked, then recovery
        do_reset();
        step(1'b1, 4'd3);
        step(1'b1, 4'd7);
        step(1'b1, 4'd6);
        step(1'b1, 4'd5);
        chk("ill_illegal",  bus_a.Illegal,  1);
        chk("ill_pulse",    bus_a.ErrPulse, 1);
        chk("ill_errcnt",   bus_a.ErrCount, 1);
        chk("ill_locked",   bus_a.Locked,   1);
        chk("ill_idx",      bus_a.Index,    3);
`ifdef SEQ_ERR_CAPTURE_EN
        cap_data = 4'd5;
        cap_exp  = 4'd6;
`else
        cap_data = 4'd0;
        cap_exp  = 4'd0;
`endif
        chk("ill_errdata",  bus_a.ErrData,  cap_data);
        chk("ill_errexp",   bus_a.ErrExp,   cap_exp);
        step(1'b1, 4'd15);
        chk("rec_pulse",    bus_a.ErrPulse, 0);
        chk("rec_illegal",  bus_a.Illegal,  0);
        chk("rec_idx",      bus_a.Index,    4);
        chk("rec_errcnt",   bus_a.ErrCount, 1);

        // two consecutive misses drop lock (miss counter was cleared by the 15)
        step(1'b1, 4'd9);
        chk("miss1_pulse",  bus_a.ErrPulse, 1);
        chk("miss1_locked", bus_a.Locked,   1);
        chk("miss1_idx",    bus_a.Index,    5);
        step(1'b1, 4'd9);
        chk("miss2_errcnt", bus_a.ErrCount, 3);
        chk("miss2_locked", bus_a.Locked,   0);
        chk("miss2_idx",    bus_a.Index,    6);
        step(1'b1, 4'd10);
        chk("rel_anchor",   bus_a.Index,    7);
        step(1'b1, 4'd12);
        step(1'b1, 4'd14);
        chk("rel_locked",   bus_a.Locked,   1);
        chk("rel_idx",      bus_a.Index,    9);
        chk("rel_expected", bus_a.Expected, 3);
        chk("rel_errcnt",   bus_a.ErrCount, 3);
        step(1'b1, 4'd3);
        chk("wrap_idx",     bus_a.Index,    0);
        chk("wrap_locked",  bus_a.Locked,   1);
        chk("wrap_errdata", bus_a.ErrData,  cap_data);

        // En=0 with garbage: nothing moves, no pulses
        step(1'b0, 4'd5);
        step(1'b0, 4'd9);
        step(1'b0, 4'd0);
        step(1'b0, 4'd15);
        chk("hold_idx",     bus_a.Index,    0);
        chk("hold_locked",  bus_a.Locked,   1);
        chk("hold_pulse",   bus_a.ErrPulse, 0);
        chk("hold_illegal", bus_a.Illegal,  0);
        chk("hold_errcnt",  bus_a.ErrCount, 3);
        step(1'b1, 4'd7);
        chk("resume_idx",   bus_a.Index,    1);
        chk("resume_lock",  bus_a.Locked,   1);

        // reset mid-lock beats an enabled anchor sample
        R = 1'b1;
        step(1'b1, 4'd15);
        R = 1'b0;
        chk("rstlk_locked", bus_a.Locked,   0);
        chk("rstlk_idx",    bus_a.Index,    0);
        chk("rstlk_exp",    bus_a.Expected, 7);
        chk("rstlk_errcnt", bus_a.ErrCount, 0);
        chk("rstlk_errdat", bus_a.ErrData,  0);
        step(1'b1, 4'd7);
        chk("rstlk_search", bus_a.Index,    0);

        // VERIFY: anchor mismatch re-anchors, other mismatch returns to SEARCH
        do_reset();
        step(1'b1, 4'd3);
        step(1'b1, 4'd15);
        chk("reanc_idx",    bus_a.Index,  4);
        step(1'b1, 4'd14);
        step(1'b1, 4'd7);
        chk("reanc_locked", bus_a.Locked, 1);
        chk("reanc_idx6",   bus_a.Index,  6);
        do_reset();
        step(1'b1, 4'd3);
        step(1'b1, 4'd6);
        step(1'b1, 4'd7);
        step(1'b1, 4'd6);
        chk("vfail_locked", bus_a.Locked, 0);
        chk("vfail_idx",    bus_a.Index,  0);
        step(1'b1, 4'd0);
        chk("srch_illegal", bus_a.Illegal,  1);
        chk("srch_pulse",   bus_a.ErrPulse, 0);
        chk("srch_errcnt",  bus_a.ErrCount, 0);

        // saturation: 6 locked mismatches, relocking between pairs
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'd3);
            step(1'b1, 4'd7);
            step(1'b1, 4'd6);
            step(1'b1, 4'd9);
            step(1'b1, 4'd9);
            chk($sformatf("sat_a_%0d", k), bus_a.ErrCount, 2 * (k + 1));
            chk($sformatf("sat_b_%0d", k), bus_b.ErrCount, (k == 0) ? 2 : 3);
            chk($sformatf("sat_lk_%0d", k), bus_b.Locked, 0);
        end
`ifdef SEQ_ERR_CAPTURE_EN
        cap_data = 4'd9;
        cap_exp  = 4'd6;
`else
        cap_data = 4'd0;
        cap_exp  = 4'd0;
`endif
        chk("sat_errdata", bus_b.ErrData, cap_data);
        chk("sat_errexp",  bus_b.ErrExp,  cap_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
